wash_phase_timer: RTL and testbench

- Timing and supervision scheduler for the washing-machine phase controller.
- Watches the controller's one-hot operation outputs and, per phase, runs a prescaled tick counter.
- Qualifies the level and temperature sensors, and generates the completion and time-out inputs the controller consumes: sig_Full, sig_Temperature, sig_Wash_Completed, sig_Rinse_Completed, sig_Spin_Completed, sig_Time_Out.
- Sits beside the controller on the same clock.

---
 rtl/wash_phase_timer.sv | 179 +++++++++++++++++
 tb/tb_wash_phase_timer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer.sv
// Phase timing and sensor supervision for the washing-machine controller.
// Optional lid pause in wash/rinse/spin: define PAUSE_ON_LID_EN.
module wash_phase_timer #(
  parameter int PRESCALE    = 1000,
  parameter int TICK_W      = 16,
  parameter int FILL_LIMIT  = 300,
  parameter int HEAT_LIMIT  = 600,
  parameter int WASH_TICKS  = 1200,
  parameter int RINSE_TICKS = 600,
  parameter int SPIN_TICKS  = 300
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fill_Water_Operation,
  input  logic              heat_Water_Operation,
  input  logic              wash_Operation,
  input  logic              rinse_Operation,
  input  logic              spin_Operation,
  input  logic              level_Sensor,
  input  logic              temp_Sensor,
  input  logic              lid_Closed,
  output logic              sig_Full,
  output logic              sig_Temperature,
  output logic              sig_Wash_Completed,
  output logic              sig_Rinse_Completed,
  output logic              sig_Spin_Completed,
  output logic              sig_Time_Out,
  output logic [2:0]        phase,
  output logic [TICK_W-1:0] ticks_Remaining
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd2,
    PH_HEAT  = 3'd3,
    PH_WASH  = 3'd4,
    PH_RINSE = 3'd5,
    PH_SPIN  = 3'd6
  } phase_e;

  phase_e            phase_r;
  phase_e            code_s;
  logic [PW-1:0]     presc_r;
  logic [PW-1:0]     presc_nxt_s;
  logic [TICK_W-1:0] ticks_r;
  logic [TICK_W-1:0] ticks_nxt_s;
  logic              wrap_s;
  logic              expire_s;
  logic              done_s;
  logic              run_s;
  logic              full_r, temp_r, wash_r, rinse_r, spin_r, tout_r;

  function automatic logic [TICK_W-1:0] limit_f(input phase_e code);
    case (code)
      PH_FILL:  limit_f = TICK_W'(FILL_LIMIT);
      PH_HEAT:  limit_f = TICK_W'(HEAT_LIMIT);
      PH_WASH:  limit_f = TICK_W'(WASH_TICKS);
      PH_RINSE: limit_f = TICK_W'(RINSE_TICKS);
      PH_SPIN:  limit_f = TICK_W'(SPIN_TICKS);
      default:  limit_f = {TICK_W{1'b0}};
    endcase
  endfunction

  // One-hot operation decode; anything else is idle
  always_comb begin
    code_s = PH_IDLE;
    case ({fill_Water_Operation, heat_Water_Operation, wash_Operation,
           rinse_Operation, spin_Operation})
      5'b10000: code_s = PH_FILL;
      5'b01000: code_s = PH_HEAT;
      5'b00100: code_s = PH_WASH;
      5'b00010: code_s = PH_RINSE;
      5'b00001: code_s = PH_SPIN;
      default:  code_s = PH_IDLE;
    endcase
  end

`ifdef PAUSE_ON_LID_EN
  assign run_s = lid_Closed | (phase_r == PH_FILL) | (phase_r == PH_HEAT);
`else
  logic unused_lid_s;
  assign unused_lid_s = lid_Closed;
  assign run_s        = 1'b1;
`endif

  // Prescaler / tick counter next values; expiry lands on the edge the count reaches zero
  always_comb begin
    wrap_s      = (presc_r == PW'(PRESCALE - 1));
    presc_nxt_s = wrap_s ? {PW{1'b0}} : presc_r + {{(PW-1){1'b0}}, 1'b1};
    if (wrap_s && (ticks_r != {TICK_W{1'b0}})) begin
      ticks_nxt_s = ticks_r - {{(TICK_W-1){1'b0}}, 1'b1};
    end else begin
      ticks_nxt_s = ticks_r;
    end
    expire_s = (ticks_r == {TICK_W{1'b0}}) ||
               (wrap_s && (ticks_r == {{(TICK_W-1){1'b0}}, 1'b1}));
    done_s   = full_r | temp_r | wash_r | rinse_r | spin_r | tout_r;
  end

  // Phase tracking, counting and sticky completion flags
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase_r <= PH_IDLE;
      presc_r <= {PW{1'b0}};
      ticks_r <= {TICK_W{1'b0}};
      full_r  <= 1'b0;
      temp_r  <= 1'b0;
      wash_r  <= 1'b0;
      rinse_r <= 1'b0;
      spin_r  <= 1'b0;
      tout_r  <= 1'b0;
    end else if (code_s != phase_r) begin
      phase_r <= code_s;
      presc_r <= {PW{1'b0}};
      ticks_r <= limit_f(code_s);
      full_r  <= 1'b0;
      temp_r  <= 1'b0;
      wash_r  <= 1'b0;
      rinse_r <= 1'b0;
      spin_r  <= 1'b0;
      tout_r  <= 1'b0;
    end else if ((phase_r != PH_IDLE) && !done_s && run_s) begin
      case (phase_r)
        PH_FILL: begin
          if (level_Sensor) begin
            full_r <= 1'b1;
          end else begin
            tout_r  <= expire_s;
            presc_r <= presc_nxt_s;
            ticks_r <= ticks_nxt_s;
          end
        end
        PH_HEAT: begin
          if (temp_Sensor) begin
            temp_r <= 1'b1;
          end else begin
            tout_r  <= expire_s;
            presc_r <= presc_nxt_s;
            ticks_r <= ticks_nxt_s;
          end
        end
        PH_WASH: begin
          wash_r  <= expire_s;
          presc_r <= presc_nxt_s;
          ticks_r <= ticks_nxt_s;
        end
        PH_RINSE: begin
          rinse_r <= expire_s;
          presc_r <= presc_nxt_s;
          ticks_r <= ticks_nxt_s;
        end
        PH_SPIN: begin
          spin_r  <= expire_s;
          presc_r <= presc_nxt_s;
          ticks_r <= ticks_nxt_s;
        end
        default: begin
          presc_r <= {PW{1'b0}};
          ticks_r <= {TICK_W{1'b0}};
        end
      endcase
    end else begin
      presc_r <= presc_r;
      ticks_r <= ticks_r;
    end
  end

  assign phase               = phase_r;
  assign ticks_Remaining     = ticks_r;
  assign sig_Full            = full_r;
  assign sig_Temperature     = temp_r;
  assign sig_Wash_Completed  = wash_r;
  assign sig_Rinse_Completed = rinse_r;
  assign sig_Spin_Completed  = spin_r;
  assign sig_Time_Out        = tout_r;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with a small timing configuration.
module tb_wash_phase_timer;

  logic        clock;
  logic        reset_n;
  logic        fill_op, heat_op, wash_op, rinse_op, spin_op;
  logic        level_sensor, temp_sensor, lid_closed;
  logic        sig_full, sig_temp, sig_wash, sig_rinse, sig_spin, sig_tout;
  logic [2:0]  phase;
  logic [15:0] ticks;
  int          n_checks = 0;
  int          n_pass   = 0;

`ifdef PAUSE_ON_LID_EN
  localparam int LID_DELAY = 7;
`else
  localparam int LID_DELAY = 0;
`endif

  wash_phase_timer #(
    .PRESCALE(4), .TICK_W(16), .FILL_LIMIT(3), .HEAT_LIMIT(2),
    .WASH_TICKS(5), .RINSE_TICKS(2), .SPIN_TICKS(0)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .fill_Water_Operation(fill_op), .heat_Water_Operation(heat_op),
    .wash_Operation(wash_op), .rinse_Operation(rinse_op), .spin_Operation(spin_op),
    .level_Sensor(level_sensor), .temp_Sensor(temp_sensor), .lid_Closed(lid_closed),
    .sig_Full(sig_full), .sig_Temperature(sig_temp), .sig_Wash_Completed(sig_wash),
    .sig_Rinse_Completed(sig_rinse), .sig_Spin_Completed(sig_spin),
    .sig_Time_Out(sig_tout), .phase(phase), .ticks_Remaining(ticks)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] sigs();
    return {26'd0, sig_full, sig_temp, sig_wash, sig_rinse, sig_spin, sig_tout};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input logic f, input logic h, input logic w, input logic r, input logic s);
    fill_op = f; heat_op = h; wash_op = w; rinse_op = r; spin_op = s;
  endtask

  initial begin
    reset_n = 1'b0; level_sensor = 1'b0; temp_sensor = 1'b0; lid_closed = 1'b1;
    set_ops(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(3);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_ticks", 32'(ticks), 32'd0);
    check("rst_sigs", sigs(), 32'd0);
    reset_n = 1'b1;
    step(1);
    check("post_rst_phase", 32'(phase), 32'd4);
    check("post_rst_ticks", 32'(ticks), 32'd5);
    set_ops(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    check("idle_phase", 32'(phase), 32'd0);
    check("idle_ticks", 32'(ticks), 32'd0);

    // fill success: sensor sampled high at edge 7
    set_ops(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    check("fill_phase", 32'(phase), 32'd2);
    check("fill_ticks", 32'(ticks), 32'd3);
    step(6);
    check("fill_pre_full", sigs(), 32'd0);
    level_sensor = 1'b1;
    step(1);
    check("fill_full", sigs(), 32'b100000);
    check("fill_frozen_ticks", 32'(ticks), 32'd2);
    level_sensor = 1'b0;
    step(6);
    check("fill_full_hold", sigs(), 32'b100000);
    check("fill_ticks_hold", 32'(ticks), 32'd2);
    set_ops(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    check("fill_exit_sigs", sigs(), 32'd0);

    // fill time-out at edge 12
    set_ops(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    step(11);
    check("tout_pre", sigs(), 32'd0);
    check("tout_pre_ticks", 32'(ticks), 32'd1);
    step(1);
    check("tout_set", sigs(), 32'b000001);
    check("tout_ticks", 32'(ticks), 32'd0);
    level_sensor = 1'b1;
    step(2);
    check("tout_no_full", sigs(), 32'b000001);
    level_sensor = 1'b0;
    set_ops(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);

    // heat: sensor on the expiry edge wins
    set_ops(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    check("heat_phase", 32'(phase), 32'd3);
    check("heat_ticks", 32'(ticks), 32'd2);
    step(7);
    check("heat_pre", sigs(), 32'd0);
    temp_sensor = 1'b1;
    step(1);
    check("heat_temp_wins", sigs(), 32'b010000);
    temp_sensor = 1'b0;
    step(2);
    check("heat_hold", sigs(), 32'b010000);
    set_ops(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);

    // wash with lid opened for 7 cycles mid-count
    set_ops(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    check("wash_ticks", 32'(ticks), 32'd5);
    step(9);
    check("wash_mid_ticks", 32'(ticks), 32'd3);
    lid_closed = 1'b0;
    step(7);
    lid_closed = 1'b1;
    check("wash_lid_ticks", 32'(ticks), (LID_DELAY != 0) ? 32'd3 : 32'd1);
    step(3 + LID_DELAY);
    check("wash_pre_done", sigs(), 32'd0);
    step(1);
    check("wash_done", sigs(), 32'b001000);
    step(3);
    check("wash_hold", sigs(), 32'b001000);
    check("wash_done_ticks", 32'(ticks), 32'd0);

    // direct wash -> rinse switch
    set_ops(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    check("rinse_phase", 32'(phase), 32'd5);
    check("rinse_ticks", 32'(ticks), 32'd2);
    check("rinse_cleared", sigs(), 32'd0);
    step(7);
    check("rinse_pre", sigs(), 32'd0);
    step(1);
    check("rinse_done", sigs(), 32'b000100);

    // spin with zero ticks completes one cycle after entry
    set_ops(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    check("spin_phase", 32'(phase), 32'd6);
    check("spin_entry_sigs", sigs(), 32'd0);
    step(1);
    check("spin_done", sigs(), 32'b000010);

    // two operations at once decode as idle
    set_ops(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1);
    check("multi_phase", 32'(phase), 32'd0);
    check("multi_sigs", sigs(), 32'd0);
    check("multi_ticks", 32'(ticks), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
